// File: rtl/lcd_timing_gen.sv
// RGB LCD video timing generator: sync/DE strobes, one-cycle-ahead pixel request and coordinates.
// Define TEST_PATTERN_EN to replace pixel_data with eight vertical colour bars.
module lcd_timing_gen #(
  parameter int H_SYNC  = 41,
  parameter int H_BACK  = 2,
  parameter int H_DISP  = 480,
  parameter int H_FRONT = 2,
  parameter int V_SYNC  = 10,
  parameter int V_BACK  = 2,
  parameter int V_DISP  = 272,
  parameter int V_FRONT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] pixel_data,
  output logic        data_req,
  output logic [10:0] xpos,
  output logic [10:0] ypos,
  output logic        frame_hsync,
  output logic        frame_vsync,
  output logic        frame_de,
  output logic [15:0] frame_rgb,
  output logic        frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int HA      = H_SYNC + H_BACK;
  localparam int VA      = V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_SYNC_END = 11'(H_SYNC);
  localparam logic [10:0] V_SYNC_END = 11'(V_SYNC);
  localparam logic [10:0] DE_H_BEG   = 11'(HA);
  localparam logic [10:0] DE_H_END   = 11'(HA + H_DISP);
  localparam logic [10:0] REQ_H_BEG  = 11'(HA - 1);
  localparam logic [10:0] REQ_H_END  = 11'(HA + H_DISP - 1);
  localparam logic [10:0] V_ACT_BEG  = 11'(VA);
  localparam logic [10:0] V_ACT_END  = 11'(VA + V_DISP);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state, state_next;
  logic [10:0] h_cnt, v_cnt;
  logic [10:0] h_next, v_next;
  logic        running, h_de, h_req, v_act;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      state <= state_next;
      h_cnt <= h_next;
      v_cnt <= v_next;
    end
  end

  // en is only honoured at the frame wrap so a frame is never cut short
  always_comb begin
    state_next = state;
    h_next     = h_cnt;
    v_next     = v_cnt;
    case (state)
      IDLE: begin
        h_next = '0;
        v_next = '0;
        if (en) state_next = RUN;
      end
      RUN: begin
        if (h_cnt == H_LAST) begin
          h_next = '0;
          if (v_cnt == V_LAST) begin
            v_next = '0;
            if (!en) state_next = IDLE;
          end else begin
            v_next = v_cnt + 11'd1;
          end
        end else begin
          h_next = h_cnt + 11'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The request window leads the display window by one column so data arrives in time
  always_comb begin
    running     = (state == RUN);
    h_de        = (h_cnt >= DE_H_BEG) && (h_cnt < DE_H_END);
    h_req       = (h_cnt >= REQ_H_BEG) && (h_cnt < REQ_H_END);
    v_act       = (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);
    frame_hsync = running && (h_cnt < H_SYNC_END);
    frame_vsync = running && (v_cnt < V_SYNC_END);
    frame_de    = running && h_de && v_act;
    data_req    = running && h_req && v_act;
    frame_start = running && (h_cnt == 11'd0) && (v_cnt == 11'd0);
    xpos        = data_req ? (h_cnt - REQ_H_BEG) : 11'd0;
    ypos        = data_req ? (v_cnt - V_ACT_BEG) : 11'd0;
  end

`ifdef TEST_PATTERN_EN
  localparam int BAR_W = H_DISP / 8;

  function automatic logic [15:0] bar_color(input logic [10:0] col);
    logic [10:0] idx;
    idx = col / 11'(BAR_W);
    case (idx)
      11'd0:   return 16'hFFFF;
      11'd1:   return 16'hFFE0;
      11'd2:   return 16'h07FF;
      11'd3:   return 16'h07E0;
      11'd4:   return 16'hF81F;
      11'd5:   return 16'hF800;
      11'd6:   return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  logic unused_pixel;
  assign unused_pixel = ^pixel_data;
  assign frame_rgb    = frame_de ? bar_color(h_cnt - DE_H_BEG) : 16'h0000;
`else
  assign frame_rgb = frame_de ? pixel_data : 16'h0000;
`endif

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen: a small-geometry instance for frame-level behaviour and a
// default-geometry instance for one full active line.
`timescale 1ns/1ps
module tb_lcd_timing_gen;
  localparam int HS = 4, HB = 2, HD = 16, HF = 2;
  localparam int VS = 2, VB = 2, VD = 6, VF = 2;
  localparam int HT = 24, VT = 12, FRAME = 288;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en;
  logic [15:0] pixel_data;
  logic        data_req, frame_hsync, frame_vsync, frame_de, frame_start;
  logic [10:0] xpos, ypos;
  logic [15:0] frame_rgb;

  logic        dflt_rst_n, dflt_en;
  logic [15:0] dflt_pixel;
  logic        dflt_req, dflt_hsync, dflt_vsync, dflt_de, dflt_start;
  logic [10:0] dflt_xpos, dflt_ypos;
  logic [15:0] dflt_rgb;

  int tests = 0;
  int fails = 0;

  lcd_timing_gen #(
    .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pixel_data(pixel_data),
    .data_req(data_req), .xpos(xpos), .ypos(ypos),
    .frame_hsync(frame_hsync), .frame_vsync(frame_vsync), .frame_de(frame_de),
    .frame_rgb(frame_rgb), .frame_start(frame_start)
  );

  lcd_timing_gen dut_dflt (
    .clk(clk), .rst_n(dflt_rst_n), .en(dflt_en), .pixel_data(dflt_pixel),
    .data_req(dflt_req), .xpos(dflt_xpos), .ypos(dflt_ypos),
    .frame_hsync(dflt_hsync), .frame_vsync(dflt_vsync), .frame_de(dflt_de),
    .frame_rgb(dflt_rgb), .frame_start(dflt_start)
  );

  // Frame source: answers each request one cycle later with {ypos[4:0], xpos}
  initial begin
    pixel_data = 16'hDEAD;
    forever begin
      @(negedge clk);
      #1;
      pixel_data = data_req ? {ypos[4:0], xpos} : 16'hDEAD;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] bar_ref(input int col, input int bar_w);
    logic [15:0] colors [8];
    colors = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    return colors[(col / bar_w) % 8];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0;
    dflt_rst_n = 1'b0; dflt_en = 1'b0; dflt_pixel = 16'h1234;
    repeat (3) @(negedge clk);
    tests++;
    if ({data_req, xpos, ypos, frame_hsync, frame_vsync, frame_de, frame_rgb, frame_start} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %h, want 0",
               {data_req, xpos, ypos, frame_hsync, frame_vsync, frame_de, frame_rgb, frame_start});
    end
    tests++;
    if ({dflt_req, dflt_xpos, dflt_ypos, dflt_hsync, dflt_vsync, dflt_de, dflt_rgb, dflt_start} !== '0) begin
      fails++;
      $display("FAIL reset_outputs_dflt: got %h, want 0",
               {dflt_req, dflt_xpos, dflt_ypos, dflt_hsync, dflt_vsync, dflt_de, dflt_rgb, dflt_start});
    end
    en = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({frame_start, frame_hsync, frame_vsync} !== 3'b000) begin
      fails++;
      $display("FAIL reset_hold_en: got %b, want 000", {frame_start, frame_hsync, frame_vsync});
    end
  endtask

  task automatic test_start();
    rst_n = 1'b1; en = 1'b1;
    @(negedge clk);
    tests++;
    if ({frame_start, frame_hsync, frame_vsync, data_req, frame_de} !== 5'b11100) begin
      fails++;
      $display("FAIL start_first_cycle: got %b, want 11100",
               {frame_start, frame_hsync, frame_vsync, data_req, frame_de});
    end
  endtask

  task automatic test_frame();
    int n_hs = 0, n_vs = 0, n_de = 0, n_req = 0, n_fs = 0;
    int bad_seq = 0, bad_pix = 0, bad_zero = 0, bad_align = 0;
    int ex = 0, ey = 0, de_lines = 0;
    logic        prev_req = 1'b0, prev_de = 1'b0;
    logic [10:0] prev_x = '0, prev_y = '0;
    logic [15:0] want;
    logic [15:0] first_px [2];
    logic [15:0] want_first [2];
    first_px = '{16'hBAD0, 16'hBAD1};
`ifdef TEST_PATTERN_EN
    want_first = '{16'hFFFF, 16'hFFFF};
`else
    want_first = '{16'h0000, 16'h0800};
`endif
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) @(negedge clk);
      n_hs += int'(frame_hsync);
      n_vs += int'(frame_vsync);
      n_de += int'(frame_de);
      n_req += int'(data_req);
      n_fs += int'(frame_start);
      if (frame_de) begin
        if (!prev_req) bad_align++;
`ifdef TEST_PATTERN_EN
        want = bar_ref(int'(prev_x), HD / 8);
`else
        want = {prev_y[4:0], prev_x};
`endif
        if (frame_rgb !== want) bad_pix++;
        if (!prev_de) begin
          if (de_lines < 2) first_px[de_lines] = frame_rgb;
          de_lines++;
        end
      end else begin
        if (prev_req) bad_align++;
        if (frame_rgb !== 16'h0000) bad_zero++;
      end
      prev_req = data_req;
      prev_de  = frame_de;
      if (data_req) begin
        if (xpos !== 11'(ex) || ypos !== 11'(ey)) bad_seq++;
        prev_x = 11'(ex);
        prev_y = 11'(ey);
        ex++;
        if (ex == HD) begin ex = 0; ey++; end
      end else if (xpos !== 11'd0 || ypos !== 11'd0) begin
        bad_seq++;
      end
    end
    tests++; if (n_hs != HS * VT) begin fails++; $display("FAIL hsync_count: got %0d, want %0d", n_hs, HS * VT); end
    tests++; if (n_vs != VS * HT) begin fails++; $display("FAIL vsync_count: got %0d, want %0d", n_vs, VS * HT); end
    tests++; if (n_de != HD * VD) begin fails++; $display("FAIL de_count: got %0d, want %0d", n_de, HD * VD); end
    tests++; if (n_req != HD * VD) begin fails++; $display("FAIL req_count: got %0d, want %0d", n_req, HD * VD); end
    tests++; if (n_fs != 1) begin fails++; $display("FAIL frame_start_count: got %0d, want 1", n_fs); end
    tests++; if (bad_seq != 0 || ey != VD) begin fails++; $display("FAIL xy_sequence: got %0d errors rows %0d, want 0 errors rows %0d", bad_seq, ey, VD); end
    tests++; if (bad_align != 0) begin fails++; $display("FAIL req_de_align: got %0d, want 0", bad_align); end
    tests++; if (bad_pix != 0) begin fails++; $display("FAIL pixel_match: got %0d errors, want 0", bad_pix); end
    tests++; if (bad_zero != 0) begin fails++; $display("FAIL rgb_blank: got %0d errors, want 0", bad_zero); end
    tests++; if (first_px[0] !== want_first[0]) begin fails++; $display("FAIL line0_first_px: got %h, want %h", first_px[0], want_first[0]); end
    tests++; if (first_px[1] !== want_first[1]) begin fails++; $display("FAIL line1_first_px: got %h, want %h", first_px[1], want_first[1]); end
    @(negedge clk);
    tests++; if (frame_start !== 1'b1) begin fails++; $display("FAIL frame_period: got %b, want 1", frame_start); end
  endtask

  task automatic test_stop();
    int n_de = 0, n_hs = 0, n_vs = 0, n_fs = 0;
    repeat (6 * HT) @(negedge clk);
    en = 1'b0;
    repeat (200) begin
      @(negedge clk);
      n_de += int'(frame_de);
      n_hs += int'(frame_hsync);
      n_vs += int'(frame_vsync);
      n_fs += int'(frame_start);
    end
    tests++; if (n_de != 64) begin fails++; $display("FAIL stop_de_tail: got %0d, want 64", n_de); end
    tests++; if (n_hs != 23) begin fails++; $display("FAIL stop_hsync_tail: got %0d, want 23", n_hs); end
    tests++; if (n_vs != 0 || n_fs != 0) begin fails++; $display("FAIL stop_no_restart: got vs %0d fs %0d, want 0 0", n_vs, n_fs); end
    tests++;
    if ({data_req, xpos, ypos, frame_hsync, frame_vsync, frame_de, frame_rgb, frame_start} !== '0) begin
      fails++;
      $display("FAIL stop_idle_outputs: got %h, want 0",
               {data_req, xpos, ypos, frame_hsync, frame_vsync, frame_de, frame_rgb, frame_start});
    end
    en = 1'b1;
    @(negedge clk);
    tests++;
    if ({frame_start, frame_hsync, frame_vsync} !== 3'b111) begin
      fails++;
      $display("FAIL restart: got %b, want 111", {frame_start, frame_hsync, frame_vsync});
    end
  endtask

  task automatic test_cancel();
    int waited = 0;
    repeat (6 * HT) @(negedge clk);
    en = 1'b0;
    repeat (100) @(negedge clk);
    en = 1'b1;
    do begin
      @(negedge clk);
      waited++;
    end while (frame_start !== 1'b1 && waited <= FRAME);
    tests++;
    if (waited != FRAME - 6 * HT - 100) begin
      fails++;
      $display("FAIL cancel_stop: got %0d cycles, want %0d", waited, FRAME - 6 * HT - 100);
    end
  endtask

  task automatic test_reset_mid();
    repeat (7 * HT + 10) @(negedge clk);
    tests++;
    if ({frame_de, data_req, xpos, ypos} !== {1'b1, 1'b1, 11'd5, 11'd3}) begin
      fails++;
      $display("FAIL mid_position: got de %b req %b x %0d y %0d, want 1 1 5 3", frame_de, data_req, xpos, ypos);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({data_req, xpos, ypos, frame_hsync, frame_vsync, frame_de, frame_rgb, frame_start} !== '0) begin
      fails++;
      $display("FAIL async_reset: got %h, want 0",
               {data_req, xpos, ypos, frame_hsync, frame_vsync, frame_de, frame_rgb, frame_start});
    end
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1;
    @(negedge clk);
    tests++;
    if ({frame_start, frame_hsync, frame_de} !== 3'b110) begin
      fails++;
      $display("FAIL reset_restart: got %b, want 110", {frame_start, frame_hsync, frame_de});
    end
  endtask

  task automatic test_default_line();
    int n_vs = 0, n_de0 = 0, n_hs = 0, n_req = 0, n_de = 0;
    int first_req = -1, first_de = -1, bad_rgb = 0;
    logic [10:0] fx = 11'h7FF, fy = 11'h7FF, lx = 11'h7FF;
    logic [15:0] want;
    dflt_rst_n = 1'b1; dflt_en = 1'b1;
    @(negedge clk);
    tests++; if (dflt_start !== 1'b1) begin fails++; $display("FAIL dflt_start: got %b, want 1", dflt_start); end
    for (int i = 0; i < 12 * 525; i++) begin
      n_vs += int'(dflt_vsync);
      n_de0 += int'(dflt_de);
      @(negedge clk);
    end
    tests++; if (n_vs != 5250) begin fails++; $display("FAIL dflt_vsync: got %0d, want 5250", n_vs); end
    tests++; if (n_de0 != 0) begin fails++; $display("FAIL dflt_blank_lines: got %0d, want 0", n_de0); end
    for (int h = 0; h < 525; h++) begin
      n_hs += int'(dflt_hsync);
      if (dflt_req) begin
        if (first_req < 0) begin first_req = h; fx = dflt_xpos; fy = dflt_ypos; end
        lx = dflt_xpos;
        n_req++;
      end
      if (dflt_de) begin
        if (first_de < 0) first_de = h;
`ifdef TEST_PATTERN_EN
        want = bar_ref(n_de, 60);
        if ((n_de == 0 || n_de == 59 || n_de == 60 || n_de == 119 || n_de == 420 || n_de == 479)
            && dflt_rgb !== want) bad_rgb++;
`else
        want = 16'h1234;
        if (dflt_rgb !== want) bad_rgb++;
`endif
        n_de++;
      end
      @(negedge clk);
    end
    tests++; if (n_hs != 41) begin fails++; $display("FAIL dflt_hsync_width: got %0d, want 41", n_hs); end
    tests++; if (n_req != 480 || n_de != 480) begin fails++; $display("FAIL dflt_line_counts: got req %0d de %0d, want 480 480", n_req, n_de); end
    tests++; if (first_req != 42 || first_de != 43) begin fails++; $display("FAIL dflt_line_start: got req %0d de %0d, want 42 43", first_req, first_de); end
    tests++; if (fx !== 11'd0 || fy !== 11'd0 || lx !== 11'd479) begin fails++; $display("FAIL dflt_xpos_range: got %0d %0d %0d, want 0 0 479", fx, fy, lx); end
    tests++; if (bad_rgb != 0) begin fails++; $display("FAIL dflt_rgb: got %0d errors, want 0", bad_rgb); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_frame();
    test_stop();
    test_cancel();
    test_reset_mid();
    test_default_line();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
